// File: rtl/clut_access_seq_pkg.sv
// Shared types and constants for the CLUT access sequencer: host FSM states,
// read-tag layout and RAM geometry.
package clut_access_seq_pkg;

  localparam int RAM_AW  = 8;
  localparam int RAM_DW  = 16;
  localparam int HOST_AW = RAM_AW - 1;
  localparam int HOST_DW = 2 * RAM_DW;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_H0   = 3'd1,
    ST_H1   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } host_st_e;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_SCAN = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   half;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_HOST, half: 1'b0};
  localparam tag_t TAG_SCAN = '{valid: 1'b1, owner: OWN_SCAN, half: 1'b0};

  // Tag for a host read of the given half; writes never produce a tag.
  function automatic tag_t host_tag(input logic is_read, input logic half);
    tag_t t;
    t.valid = is_read;
    t.owner = OWN_HOST;
    t.half  = half;
    return t;
  endfunction

endpackage

// File: rtl/clut_access_seq_if.sv
// Requester-side bus of the CLUT access sequencer: 32-bit host register port
// plus the scan-out index/data stream.
interface clut_access_seq_if;
  import clut_access_seq_pkg::*;

  logic               h_req;
  logic               h_rw;
  logic [HOST_AW-1:0] h_addr;
  logic [HOST_DW-1:0] h_wdata;
  logic               h_ack;
  logic [HOST_DW-1:0] h_rdata;
  logic               s_valid;
  logic [RAM_AW-1:0]  s_idx;
  logic               s_ready;
  logic               p_valid;
  logic [RAM_DW-1:0]  p_data;

  modport master (
    output h_req, h_rw, h_addr, h_wdata, s_valid, s_idx,
    input  h_ack, h_rdata, s_ready, p_valid, p_data
  );

  modport slave (
    input  h_req, h_rw, h_addr, h_wdata, s_valid, s_idx,
    output h_ack, h_rdata, s_ready, p_valid, p_data
  );

endinterface

// File: rtl/clut_access_seq_tag_pipe.sv
// Read-tag shift register: pairs each RAM read return with its owner and
// steers the data into the scan output or the matching host read half.
module clut_access_seq_tag_pipe
  import clut_access_seq_pkg::*;
(
  input  logic               sys_clk,
  input  logic               resetl,
  input  tag_t               issue_tag,
  input  logic [RAM_DW-1:0]  z_out,
  input  logic               z_oe,
  output logic               host_h1_cap,
  output logic               p_valid,
  output logic [RAM_DW-1:0]  p_data,
  output logic [HOST_DW-1:0] h_rdata
);

  tag_t               tag_s0_r;
  tag_t               tag_s1_r;
  logic               take_s;
  logic [RAM_DW-1:0]  p_data_r;
  logic [HOST_DW-1:0] h_rdata_r;

  // A return with no tag behind it is dropped.
  assign take_s      = z_oe & tag_s0_r.valid;
  assign host_h1_cap = take_s & (tag_s0_r.owner == OWN_HOST) & tag_s0_r.half;

  // Tag shift and data capture.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      tag_s0_r  <= TAG_NONE;
      tag_s1_r  <= TAG_NONE;
      p_data_r  <= {RAM_DW{1'b0}};
      h_rdata_r <= {HOST_DW{1'b0}};
    end else begin
      tag_s0_r <= issue_tag;
      tag_s1_r <= take_s ? tag_s0_r : TAG_NONE;
      if (take_s && (tag_s0_r.owner == OWN_SCAN)) begin
        p_data_r <= z_out;
      end else if (take_s && !tag_s0_r.half) begin
        h_rdata_r[HOST_DW-1:RAM_DW] <= z_out;
      end else if (take_s) begin
        h_rdata_r[RAM_DW-1:0] <= z_out;
      end
    end
  end

  // Second stage marks the cycle in which captured scan data is presented.
  assign p_valid = (tag_s1_r == TAG_SCAN);
  assign p_data  = p_data_r;
  assign h_rdata = h_rdata_r;

endmodule

// File: rtl/clut_access_seq.sv
// Arbitrates the host register port and the scan index stream onto the
// single-port 256x16 palette RAM; scan wins, a starvation counter guarantees host progress.
module clut_access_seq
  import clut_access_seq_pkg::*;
#(
  parameter int STARVE_LIM = 8,
  parameter int CNT_W      = 8
) (
  input  logic              sys_clk,
  input  logic              resetl,
  clut_access_seq_if.slave  bus,
  output logic              cen,
  output logic              rw,
  output logic [RAM_AW-1:0] a,
  output logic [RAM_DW-1:0] z_in,
  input  logic [RAM_DW-1:0] z_out,
  input  logic              z_oe
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIM - 1);

  host_st_e         state_r;
  logic             h_ack_r;
  logic             s_ready_r;
  logic [CNT_W-1:0] starve_cnt_r;
  logic             scan_gnt_s;
  logic             host_busy_s;
  logic             host_gnt_s;
  logic             host_half_s;
  logic             host_h1_cap_s;
  tag_t             issue_tag_s;

  assign scan_gnt_s  = bus.s_valid & s_ready_r;
  assign host_busy_s = (state_r == ST_H0) | (state_r == ST_H1);
  assign host_gnt_s  = host_busy_s & ~scan_gnt_s;
  assign host_half_s = (state_r == ST_H1);

  // RAM port drive and read-tag generation for the current owner.
  always_comb begin
    cen         = 1'b1;
    rw          = 1'b1;
    a           = {RAM_AW{1'b0}};
    z_in        = {RAM_DW{1'b0}};
    issue_tag_s = TAG_NONE;
    if (scan_gnt_s) begin
      cen         = 1'b0;
      a           = bus.s_idx;
      issue_tag_s = TAG_SCAN;
    end else if (host_gnt_s) begin
      cen         = 1'b0;
      rw          = bus.h_rw;
      a           = {bus.h_addr, host_half_s};
      issue_tag_s = host_tag(bus.h_rw, host_half_s);
      if (bus.h_rw) begin
        z_in = {RAM_DW{1'b0}};
      end else begin
        z_in = host_half_s ? bus.h_wdata[RAM_DW-1:0] : bus.h_wdata[HOST_DW-1:RAM_DW];
      end
    end else begin
      cen = 1'b1;
    end
  end

  // Host transaction FSM; h_req is only sampled in IDLE.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_r <= ST_IDLE;
      h_ack_r <= 1'b0;
    end else begin
      h_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.h_req) begin
            state_r <= ST_H0;
          end
        end
        ST_H0: begin
          if (host_gnt_s) begin
            state_r <= ST_H1;
          end
        end
        ST_H1: begin
          if (host_gnt_s && bus.h_rw) begin
            state_r <= ST_WAIT;
          end else if (host_gnt_s) begin
            state_r <= ST_DONE;
            h_ack_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (host_h1_cap_s) begin
            state_r <= ST_DONE;
            h_ack_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Starvation counter: after STARVE_LIM scan wins over a pending host half,
  // s_ready drops for one cycle so the host takes the port.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      starve_cnt_r <= CNT_ZERO;
      s_ready_r    <= 1'b1;
    end else begin
      s_ready_r <= 1'b1;
      if (!host_busy_s || host_gnt_s) begin
        starve_cnt_r <= CNT_ZERO;
      end else if (scan_gnt_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_ONE;
        if (starve_cnt_r == STARVE_LAST) begin
          s_ready_r <= 1'b0;
        end
      end
    end
  end

  clut_access_seq_tag_pipe u_tag_pipe (
    .sys_clk     (sys_clk),
    .resetl      (resetl),
    .issue_tag   (issue_tag_s),
    .z_out       (z_out),
    .z_oe        (z_oe),
    .host_h1_cap (host_h1_cap_s),
    .p_valid     (bus.p_valid),
    .p_data      (bus.p_data),
    .h_rdata     (bus.h_rdata)
  );

  assign bus.h_ack   = h_ack_r;
  assign bus.s_ready = s_ready_r;

endmodule

// File: doc/clut_access_seq.md
Name: clut_access_seq

Overview:
- Access sequencer that sits directly upstream of the 256x16 single-port palette/line RAM.
- Arbitrates two requesters onto the RAM's single port (cen, rw, a, z_in) and routes returned data (z_out, z_oe) back to the owner:
  - a 32-bit host bus port (register-style read/write);
  - a 16-bit scan-out index stream.
- Scan has priority. An anti-starvation counter guarantees host progress.

Parameters:
STARVE_LIM, 8, consecutive scan-granted cycles with a pending host half before s_ready is forced low for one cycle (valid 1..255)
CNT_W, 8, width of the starvation counter; must hold STARVE_LIM

Ports:
sys_clk  in  1  single clock
resetl  in  1  asynchronous active-low reset
h_req  in  1  host request; held until h_ack
h_rw  in  1  1=read, 0=write; stable while h_req
h_addr  in  7  32-bit word address; RAM addresses {h_addr,0} and {h_addr,1}
h_wdata  in  32  write data; [31:16] to half 0, [15:0] to half 1
h_ack  out  1  one-cycle completion pulse
h_rdata  out  32  read data; valid while h_ack=1
s_valid  in  1  scan index valid
s_idx  in  8  RAM address to read
s_ready  out  1  scan index accepted when s_valid & s_ready
p_valid  out  1  scan data valid pulse
p_data  out  16  scan data
cen  out  1  RAM chip enable, active low
rw  out  1  RAM 1=read, 0=write
a  out  8  RAM address
z_in  out  16  RAM write data
z_out  in  16  RAM read data; registered, valid the cycle after the read issue
z_oe  in  1  RAM read-valid; high the cycle after a read issue

Behaviour:
- RAM port outputs are combinational from state and inputs; the RAM samples on sys_clk rise. Idle values: cen=1, rw=1, a=0, z_in=0.
- Host FSM states:
  - IDLE -> H0 on h_req.
  - H0 issues half 0; advances to H1 only in a cycle it owns the port.
  - H1 issues half 1; advances to WAIT on a granted read, or to DONE on a granted write.
  - WAIT -> DONE when half-1 data is captured.
  - DONE pulses h_ack for one cycle -> IDLE.
  - h_req is not resampled in DONE, so back-to-back requests take at least one idle cycle.
- Port grant each cycle:
  - Scan owns the port if s_valid & s_ready.
  - Otherwise host owns it in H0/H1.
  - Otherwise the port is idle.
- s_ready=1 except for exactly one cycle after the starvation counter reaches STARVE_LIM.
- Starvation counter:
  - Increments on each scan-granted cycle while the host FSM is in H0/H1.
  - Clears on a host-granted cycle, or when the FSM is in any other state.
- Tag pipeline: a 2-stage shift of {valid, owner, half}, loaded at each read issue. The tag for cycle N read is consumed in N+1 together with z_out/z_oe.
- z_oe=1 with an empty tag is ignored.
- Scan read latency: s_idx accepted in cycle N -> p_valid=1, p_data=RAM[s_idx] in cycle N+2 (z_out registered into p_data at the end of N+1). Full throughput of 1 index/cycle.
- Host read: half 0 data latched into h_rdata[31:16] and half 1 into [15:0] as they return. h_ack asserts the cycle after the half-1 capture.
- Host write: no read-back. h_ack follows the half-1 issue cycle.
- A scan read after a host write to the same address returns the new data (RAM new-data semantics). The sequencer adds no forwarding.
- Host halves may be split by arbitrarily many scan cycles, bounded by STARVE_LIM+1 per half.
- Reset (async, any time, including mid-transaction):
  - FSM -> IDLE; tags and counter cleared.
  - h_ack=0, h_rdata=0, p_valid=0, p_data=0, s_ready=1, cen=1, rw=1.
  - An interrupted transaction is dropped with no ack; a host write may have completed half 0 only.

Decomposition:
- Shared package: host FSM state encoding (IDLE/H0/H1/WAIT/DONE), tag struct fields (valid, owner enum HOST/SCAN, half), and RAM_AW=8 / RAM_DW=16 constants.
- One sub-module is natural: clut_tag_pipe (2-stage tag shift register plus data capture/steering).

Test Plan:
1. Host write h_addr=7'h05, h_wdata=32'hDEAD_BEEF with scan idle -> RAM[0x0A]=16'hDEAD, RAM[0x0B]=16'hBEEF; h_ack pulses 3 cycles after h_req rises.
2. Host read of addr 7'h05 after test 1 -> h_rdata=32'hDEAD_BEEF with one h_ack pulse; no p_valid.
3. Scan stream s_idx=0x0A,0x0B,0x0C on consecutive cycles with s_valid held -> p_valid on 3 consecutive cycles starting 2 cycles after the first accept, p_data=DEAD,BEEF,RAM[0x0C].
4. Continuous s_valid while a host read is pending, STARVE_LIM=8 -> s_ready low exactly once every 9 cycles; host completes in at most 2×9+3 cycles; h_rdata correct and no scan data misrouted.
5. Interleave: scan accepted in the cycle between host H0 and H1 grants -> p_data and h_rdata halves each land at the correct destination per tag.
6. Assert resetl=0 while the FSM is in WAIT -> outputs return to reset values immediately; no h_ack after resetl releases; the next host read completes normally.
